// File: rtl/demodchest_regs_pkg.sv
// demodchest_regs_pkg: register offsets, field positions and defaults for the demodchest CtrlPort responder
package demodchest_regs_pkg;
  localparam logic [4:0] REG_COMPAT  = 5'h00;
  localparam logic [4:0] REG_CTRL    = 5'h04;
  localparam logic [4:0] REG_THRESH  = 5'h08;
  localparam logic [4:0] REG_STATUS  = 5'h0C;
  localparam logic [4:0] REG_CNT_LO  = 5'h10;
  localparam logic [4:0] REG_CNT_HI  = 5'h14;
  localparam logic [4:0] REG_SCRATCH = 5'h18;
  localparam logic [4:0] REG_UNMAP   = 5'h1C;
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int STATUS_OVF_BIT  = 0;
  localparam int THRESH_W        = 16;
  localparam logic [31:0] COMPAT_DEFAULT = 32'h0001_0000;
endpackage

// File: rtl/demodchest_event_counter.sv
// demodchest_event_counter: 64-bit event counter with clear priority and hi-word snapshot (clk, rst, i_inc, i_clear, i_snap -> o_cnt, o_shadow)
module demodchest_event_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_clear,
  input  logic        i_snap,
  output logic [63:0] o_cnt,
  output logic [31:0] o_shadow
);
  logic [63:0] r_cnt;
  logic [31:0] r_shadow;
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_cnt    <= r_cnt + {63'b0, i_inc};
      r_shadow <= i_snap ? r_cnt[63:32] : r_shadow;
    end
  assign o_cnt    = r_cnt;
  assign o_shadow = r_shadow;
endmodule

// File: rtl/demodchest_ctrlport_regs.sv
// demodchest_ctrlport_regs: CtrlPort register responder (req wr/rd/addr/data -> 1-cycle ack/data; ctrl_enable, ctrl_thresh; cnt_event, ovf_event)
module demodchest_ctrlport_regs
  import demodchest_regs_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR    = 20'h00000,
  parameter logic [31:0] COMPAT       = COMPAT_DEFAULT,
  parameter bit          ACK_UNMAPPED = 1'b1
) (
  input  logic          ctrlport_clk,
  input  logic          ctrlport_rst,
  input  logic          s_ctrlport_req_wr,
  input  logic          s_ctrlport_req_rd,
  input  logic [19:0]   s_ctrlport_req_addr,
  input  logic [31:0]   s_ctrlport_req_data,
  output logic          s_ctrlport_resp_ack,
  output logic [31:0]   s_ctrlport_resp_data,
  output logic          ctrl_enable,
  output logic [THRESH_W-1:0] ctrl_thresh,
  input  logic          cnt_event,
  input  logic          ovf_event
);
  logic [17:0] w_word;
  logic        w_hit;
  logic [4:0]  w_reg;
  logic        w_resp;
  logic        w_wr;
  logic        w_unused_addr;
  logic [31:0] w_rdata;
  logic [63:0] w_cnt;
  logic [31:0] w_shadow;
  logic        r_ack;
  logic [31:0] r_data;
  logic        r_enable;
  logic [THRESH_W-1:0] r_thresh;
  logic [31:0] r_scratch;
  logic        r_ovf;
  // Word-granular offset; a wrapped subtraction also rejects addresses below the base.
  assign w_word        = s_ctrlport_req_addr[19:2] - BASE_ADDR[19:2];
  assign w_unused_addr = ^s_ctrlport_req_addr[1:0];
  assign w_hit  = w_word[17:3] == '0;
  assign w_reg  = {w_word[2:0], 2'b00};
  assign w_resp = w_hit && (s_ctrlport_req_wr || s_ctrlport_req_rd) && (w_reg != REG_UNMAP || ACK_UNMAPPED);
  assign w_wr   = s_ctrlport_req_wr && w_hit;
  // Read mux sees pre-edge state, so a same-cycle write returns the old value.
  always_comb
    w_rdata = w_reg == REG_COMPAT  ? COMPAT :
              w_reg == REG_CTRL    ? {31'b0, r_enable} :
              w_reg == REG_THRESH  ? {{(32-THRESH_W){1'b0}}, r_thresh} :
              w_reg == REG_STATUS  ? {31'b0, r_ovf} :
              w_reg == REG_CNT_LO  ? w_cnt[31:0] :
              w_reg == REG_CNT_HI  ? w_shadow :
              w_reg == REG_SCRATCH ? r_scratch : 32'h0;
  demodchest_event_counter u_cnt (
    .clk      (ctrlport_clk),
    .rst      (ctrlport_rst),
    .i_inc    (cnt_event),
    .i_clear  (w_wr && w_reg == REG_CTRL && s_ctrlport_req_data[CTRL_CLEAR_BIT]),
    .i_snap   (s_ctrlport_req_rd && w_hit && w_reg == REG_CNT_LO),
    .o_cnt    (w_cnt),
    .o_shadow (w_shadow)
  );
  always_ff @(posedge ctrlport_clk)
    if (ctrlport_rst) begin
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_enable  <= 1'b0;
      r_thresh  <= '0;
      r_scratch <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ack  <= w_resp;
      r_data <= (w_resp && s_ctrlport_req_rd) ? w_rdata : 32'h0;
      if (w_wr && w_reg == REG_CTRL)    r_enable  <= s_ctrlport_req_data[CTRL_ENABLE_BIT];
      if (w_wr && w_reg == REG_THRESH)  r_thresh  <= s_ctrlport_req_data[THRESH_W-1:0];
      if (w_wr && w_reg == REG_SCRATCH) r_scratch <= s_ctrlport_req_data;
      // Set wins over a concurrent write-one-to-clear.
      r_ovf <= ovf_event || (r_ovf && !(w_wr && w_reg == REG_STATUS && s_ctrlport_req_data[STATUS_OVF_BIT]));
    end
  assign s_ctrlport_resp_ack  = r_ack;
  assign s_ctrlport_resp_data = r_data;
  assign ctrl_enable          = r_enable;
  assign ctrl_thresh          = r_thresh;
endmodule

// File: tb/tb_demodchest_ctrlport_regs.sv
// tb_demodchest_ctrlport_regs: directed and randomized checks of the CtrlPort responder against a register-map model
module tb_demodchest_ctrlport_regs;
  localparam logic [19:0] BASE = 20'h00000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_wr = 1'b0;
  logic        req_rd = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        ctrl_enable;
  logic [15:0] ctrl_thresh;
  logic        cnt_event = 1'b0;
  logic        ovf_event = 1'b0;
  int checks = 0;
  int failures = 0;
  logic        m_en;
  logic [15:0] m_th;
  logic [31:0] m_sc;
  logic        m_ovf;
  logic [63:0] m_cnt;
  logic [31:0] m_sh;
  logic        exp_ack;
  logic [31:0] exp_data;
  demodchest_ctrlport_regs #(.BASE_ADDR(BASE)) dut (
    .ctrlport_clk         (clk),
    .ctrlport_rst         (rst),
    .s_ctrlport_req_wr    (req_wr),
    .s_ctrlport_req_rd    (req_rd),
    .s_ctrlport_req_addr  (req_addr),
    .s_ctrlport_req_data  (req_data),
    .s_ctrlport_resp_ack  (resp_ack),
    .s_ctrlport_resp_data (resp_data),
    .ctrl_enable          (ctrl_enable),
    .ctrl_thresh          (ctrl_thresh),
    .cnt_event            (cnt_event),
    .ovf_event            (ovf_event)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0: return 32'h0001_0000;
      1: return {31'b0, m_en};
      2: return {16'b0, m_th};
      3: return {31'b0, m_ovf};
      4: return m_cnt[31:0];
      5: return m_sh;
      6: return m_sc;
      default: return 32'h0;
    endcase
  endfunction
  // One clock: drive at negedge, predict, check at the following negedge.
  task automatic step(input string tag, input bit wr, input bit rd, input logic [19:0] addr,
                      input logic [31:0] data, input bit ce, input bit oe, input bit rs);
    logic [19:0] off;
    bit hit;
    int idx;
    logic [63:0] cnt_n;
    logic [31:0] sh_n;
    rst = rs; req_wr = wr; req_rd = rd; req_addr = addr; req_data = data;
    cnt_event = ce; ovf_event = oe;
    off = addr - BASE;
    hit = off < 20'h20;
    idx = int'(off[4:2]);
    if (rs) begin
      {m_en, m_th, m_sc, m_ovf, m_cnt, m_sh} = '0;
      exp_ack = 1'b0; exp_data = 32'h0;
    end else begin
      exp_ack  = (wr || rd) && hit;
      exp_data = (rd && hit) ? model_read(idx) : 32'h0;
      cnt_n = m_cnt + 64'(ce);
      sh_n  = (rd && hit && idx == 4) ? m_cnt[63:32] : m_sh;
      if (wr && hit && idx == 1 && data[1]) begin cnt_n = '0; sh_n = '0; end
      m_cnt = cnt_n; m_sh = sh_n;
      if (wr && hit && idx == 1) m_en = data[0];
      if (wr && hit && idx == 2) m_th = data[15:0];
      if (wr && hit && idx == 6) m_sc = data;
      m_ovf = oe || (m_ovf && !(wr && hit && idx == 3 && data[0]));
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    assert (resp_ack === exp_ack) else begin failures++; $error("FAIL %s ack got %0b want %0b", tag, resp_ack, exp_ack); end
    checks++;
    assert (resp_data === exp_data) else begin failures++; $error("FAIL %s data got %08h want %08h", tag, resp_data, exp_data); end
    checks++;
    assert (ctrl_enable === m_en) else begin failures++; $error("FAIL %s enable got %0b want %0b", tag, ctrl_enable, m_en); end
    checks++;
    assert (ctrl_thresh === m_th) else begin failures++; $error("FAIL %s thresh got %04h want %04h", tag, ctrl_thresh, m_th); end
  endtask
  initial begin
    @(negedge clk);
    step("reset0", 0, 0, 0, 0, 0, 0, 1);
    step("reset1", 1, 1, 20'h18, 32'h1, 1, 1, 1);
    for (int i = 0; i < 8; i++) step("rdinit", 0, 1, BASE + 20'(i * 4), 0, 0, 0, 0);
    checks++;
    step("rdcompat", 0, 1, BASE, 0, 0, 0, 0);
    assert (resp_data === 32'h0001_0000) else begin failures++; $error("FAIL compat got %08h want 00010000", resp_data); end
    step("wrscr", 1, 0, BASE + 20'h18, 32'hDEAD_BEEF, 0, 0, 0);
    step("rdscr", 0, 1, BASE + 20'h18, 0, 0, 0, 0);
    step("wrth", 1, 0, BASE + 20'h08, 32'hFFFF_1234, 0, 0, 0);
    checks++;
    assert (ctrl_thresh === 16'h1234) else begin failures++; $error("FAIL thresh_lit got %04h want 1234", ctrl_thresh); end
    step("rdth", 0, 1, BASE + 20'h08, 0, 0, 0, 0);
    force dut.u_cnt.r_cnt = 64'h0000_0001_FFFF_FFFF;
    m_cnt = 64'h0000_0001_FFFF_FFFF;
    step("preload", 0, 0, 0, 0, 0, 0, 0);
    release dut.u_cnt.r_cnt;
    step("carry", 0, 0, 0, 0, 1, 0, 0);
    step("rdlo", 0, 1, BASE + 20'h10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("ev", 0, 0, 0, 0, 1, 0, 0);
    step("rdhi", 0, 1, BASE + 20'h14, 0, 0, 0, 0);
    step("rdlo2", 0, 1, BASE + 20'h10, 0, 0, 0, 0);
    step("ovf", 0, 0, 0, 0, 0, 1, 0);
    step("rdst1", 0, 1, BASE + 20'h0C, 0, 0, 0, 0);
    step("w1c_set", 1, 0, BASE + 20'h0C, 32'h1, 0, 1, 0);
    step("rdst2", 0, 1, BASE + 20'h0C, 0, 0, 0, 0);
    step("w1c", 1, 0, BASE + 20'h0C, 32'h1, 0, 0, 0);
    step("rdst3", 0, 1, BASE + 20'h0C, 0, 0, 0, 0);
    step("ctrl3", 1, 0, BASE + 20'h04, 32'h3, 1, 0, 0);
    step("rdcnt0", 0, 1, BASE + 20'h10, 0, 0, 0, 0);
    step("rdctrl", 0, 1, BASE + 20'h04, 0, 0, 0, 0);
    step("oow_rd", 0, 1, BASE + 20'h40, 0, 0, 0, 0);
    step("oow_wr", 1, 0, BASE + 20'h58, 32'hFFFF_FFFF, 0, 0, 0);
    step("unmap", 1, 1, BASE + 20'h1C, 32'h55, 0, 0, 0);
    step("wr5", 1, 0, BASE + 20'h18, 32'h5, 0, 0, 0);
    step("rdwr", 1, 1, BASE + 20'h18, 32'h7, 0, 0, 0);
    checks++;
    assert (resp_data === 32'h5) else begin failures++; $error("FAIL rdwr_lit got %08h want 00000005", resp_data); end
    step("rd7", 0, 1, BASE + 20'h1B, 0, 0, 0, 0);
    step("rst_mid", 0, 1, BASE, 0, 1, 1, 1);
    step("post_rst", 0, 1, BASE + 20'h18, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [19:0] a;
      a = ($urandom_range(0, 15) == 0) ? 20'($urandom) : BASE + 20'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, a, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
